lsu_mem_stage: RTL
==================

Name: lsu_mem_stage

Overview:
Memory-stage load/store unit: the consumer of the execute-to-memory pipeline register. Takes the address, store data, opcode, func3 and mem_write fields of the instruction now in the memory stage and runs one req/ack transaction per access on the data bus. Stalls the pipeline while the access is in flight. Returns sign/zero-extended load data to the writeback mux, and flags misaligned, illegal or timed-out accesses.

Parameters:
DW, 32, data/address width (only 32 supported)
TIMEOUT, 16, cycles to wait for dbus_ack_i before aborting with an error (range 2..255)

Ports:
clk_i  input  1  clock
rst_ni  input  1  synchronous active-low reset
alu_out_m  input  DW  effective byte address
write_data_m  input  DW  store data, rs2 unshifted
mem_write_m  input  1  store instruction
opcode_m  input  7  opcode; 7'b0000011 = load
func3_m  input  3  access size/sign
dbus_req_o  output  1  bus request, held until ack or timeout
dbus_we_o  output  1  write enable
dbus_addr_o  output  DW  word-aligned address {addr[31:2],2'b00}
dbus_wdata_o  output  DW  store data shifted to byte lanes
dbus_be_o  output  4  byte enables
dbus_ack_i  input  1  one-cycle completion; rdata valid same cycle
dbus_rdata_i  input  DW  read word
load_data_o  output  DW  extended load result, valid in DONE
stall_o  output  1  freeze IF/EX and the E->M register
lsu_err_o  output  1  one-cycle error pulse (misaligned, illegal func3, timeout)

Behaviour:
- access = mem_write_m | (opcode_m==7'b0000011).
- Load func3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Store func3: 000 SB, 001 SH, 010 SW. Any other func3 with access set is illegal.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
- Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
- Write data: wdata = write_data_m << (8*addr[1:0]), using the low byte or halfword replicated into the selected lanes.
- Load extraction: shift rdata right by 8*addr[1:0], then extend bit 7 or 15 (LB/LH) or zero-extend (LBU/LHU).
- FSM states: IDLE, REQ, DONE.
- IDLE, access legal and aligned: stall_o=1 combinationally. Next edge: register addr/be/wdata/we/func3/addr[1:0], set dbus_req_o=1, go to REQ, clear the timeout counter.
- IDLE, access illegal or misaligned: lsu_err_o=1 combinationally for that cycle. No request, no stall; the instruction retires with no bus effect.
- IDLE, no access: outputs idle, stall_o=0.
- REQ: stall_o=1 and bus outputs stable.
  - ack=1: capture the extended rdata into load_data_o, drop req next edge, go to DONE.
  - ack=0: increment the counter. At count==TIMEOUT-1, drop req, pulse lsu_err_o in the DONE cycle, set load_data_o=0, go to DONE.
- DONE: stall_o=0 so the pipeline advances exactly once, then return to IDLE. A back-to-back access arriving in the next cycle is handled by IDLE as new.
- Ack in IDLE or DONE is ignored.
- Bus-visible latency of a load: request asserted 1 cycle after the instruction enters M. Result is available the cycle after ack. Minimum stall is 2 cycles (IDLE + REQ with immediate ack).
- Reset (rst_ni=0 at an edge): state IDLE, dbus_req_o=0, dbus_we_o=0, dbus_addr_o=0, dbus_wdata_o=0, dbus_be_o=0, load_data_o=0, lsu_err_o=0, counter=0. Reset during REQ drops req at that edge; an ack arriving afterwards is ignored.
- stall_o is 0 while rst_ni=0.

Test Plan:
1. LW addr 0x100, ack after 3 cycles with rdata 0xDEADBEEF -> req held for 3 cycles, be=4'b1111, addr 0x100, load_data_o=0xDEADBEEF in DONE, stall_o high for 4 cycles.
2. LB and LBU addr 0x203 with rdata 0x80FF_1234 -> LB gives 0xFFFFFF80; LBU gives 0x00000080.
3. SH addr 0x32, write_data_m 0x0000ABCD -> we=1, be=4'b1100, wdata=0xABCD_xxxx lanes [31:16]=0xABCD, addr 0x30.
4. LW addr 0x102 -> lsu_err_o pulses one cycle, dbus_req_o never rises, stall_o=0. func3=3'b011 load behaves the same.
5. TIMEOUT=16 with no ack -> req high exactly 16 cycles, then lsu_err_o pulse and load_data_o=0 in DONE, IDLE afterwards.
6. rst_ni low for 1 cycle during REQ with a late ack -> req=0 after the edge, state IDLE, stall_o=0, ack ignored. Back-to-back SW then LW both complete with no lost or duplicated request.

Source files
------------

// File: rtl/lsu_mem_stage.sv
// Memory-stage LSU: one req/ack bus transaction per load/store, sized lanes, sign/zero-extended load data.
// Latency: request one cycle after entry to M, result the cycle after ack. Stall is held while the access is in flight.
module lsu_mem_stage #(
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [DW-1:0] alu_out_m,
  input  logic [DW-1:0] write_data_m,
  input  logic          mem_write_m,
  input  logic [6:0]    opcode_m,
  input  logic [2:0]    func3_m,
  output logic          dbus_req_o,
  output logic          dbus_we_o,
  output logic [DW-1:0] dbus_addr_o,
  output logic [DW-1:0] dbus_wdata_o,
  output logic [3:0]    dbus_be_o,
  input  logic          dbus_ack_i,
  input  logic [DW-1:0] dbus_rdata_i,
  output logic [DW-1:0] load_data_o,
  output logic          stall_o,
  output logic          lsu_err_o
);

  localparam logic [6:0] OP_LOAD = 7'b0000011;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t        state;
  logic [7:0]    cnt;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;
  logic          err_q;
  logic          access, legal, aligned, go, bad;
  logic [1:0]    off;
  logic [3:0]    be_c;
  logic [DW-1:0] wdata_c;
  logic [DW-1:0] rsh;
  logic [DW-1:0] ext;

  assign off    = alu_out_m[1:0];
  assign access = mem_write_m | (opcode_m == OP_LOAD);

  always_comb begin
    legal   = 1'b0;
    aligned = 1'b1;
    be_c    = 4'b1111;
    wdata_c = write_data_m;
    case (func3_m)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !mem_write_m;
      default:                legal = 1'b0;
    endcase
    case (func3_m[1:0])
      2'b00: begin
        be_c    = 4'b0001 << off;
        wdata_c = {{(DW-8){1'b0}}, write_data_m[7:0]} << {off, 3'b000};
      end
      2'b01: begin
        aligned = !off[0];
        be_c    = 4'b0011 << off;
        wdata_c = {{(DW-16){1'b0}}, write_data_m[15:0]} << {off, 3'b000};
      end
      default: aligned = (off == 2'b00);
    endcase
  end

  assign go  = access & legal & aligned;
  assign bad = access & !(legal & aligned);

  // Extraction uses the size/offset latched at request time, not the live M-stage fields.
  always_comb begin
    rsh = dbus_rdata_i >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ext = {{(DW-8){rsh[7]}}, rsh[7:0]};
      3'b001:  ext = {{(DW-16){rsh[15]}}, rsh[15:0]};
      3'b100:  ext = {{(DW-8){1'b0}}, rsh[7:0]};
      3'b101:  ext = {{(DW-16){1'b0}}, rsh[15:0]};
      default: ext = rsh;
    endcase
  end

  assign stall_o   = rst_ni & (((state == IDLE) & go) | (state == REQ));
  assign lsu_err_o = rst_ni & (((state == IDLE) & bad) | err_q);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state        <= IDLE;
      cnt          <= '0;
      f3_q         <= '0;
      off_q        <= '0;
      err_q        <= 1'b0;
      dbus_req_o   <= 1'b0;
      dbus_we_o    <= 1'b0;
      dbus_addr_o  <= '0;
      dbus_wdata_o <= '0;
      dbus_be_o    <= '0;
      load_data_o  <= '0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            state        <= REQ;
            cnt          <= '0;
            dbus_req_o   <= 1'b1;
            dbus_we_o    <= mem_write_m;
            dbus_addr_o  <= {alu_out_m[DW-1:2], 2'b00};
            dbus_be_o    <= be_c;
            dbus_wdata_o <= wdata_c;
            f3_q         <= func3_m;
            off_q        <= off;
          end
        end
        REQ: begin
          if (dbus_ack_i) begin
            load_data_o <= ext;
            dbus_req_o  <= 1'b0;
            dbus_we_o   <= 1'b0;
            state       <= DONE;
          end else if (cnt == 8'(TIMEOUT - 1)) begin
            load_data_o <= '0;
            dbus_req_o  <= 1'b0;
            dbus_we_o   <= 1'b0;
            err_q       <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
